memo_elastic_pipe: RTL and testbench
====================================

// Module: memo_elastic_pipe
// PURPOSE
//  Parametrised multi-channel elastic pipeline with per-channel accumulators and a flush FSM.
//  Generalises the single-bit wire/comb/seq/ff chain to WIDTH x CHANNELS data, DEPTH register stages,
//  valid/ready flow control and signed/unsigned modes.
//  Serves as an elaboration fixture covering assign, always_comb, always_ff, async reset, enum FSM,
//  generate loops and sub-module arrays; must also simulate correctly.
// PARAMETERS
//  WIDTH       8  bits per channel
//  CHANNELS    2  number of parallel data lanes
//  DEPTH       3  register stages from input to output; >=1
//  SIGNED_MODE 1  1: sign-extend lanes into accumulators; 0: zero-extend
//  ACC_W      16  accumulator width per channel; >= WIDTH
// PORTS
//  clk        in   1               single clock, all state on posedge
//  rst        in   1               asynchronous, active-high reset
//  in_valid   in   1               upstream beat valid
//  in_ready   out  1               pipeline accepts beat this cycle
//  in_data    in   CHANNELS*WIDTH  lane c at [c*WIDTH +: WIDTH]
//  in_chan_en in   CHANNELS        per-lane enable; disabled lane captured as 0
//  out_valid  out  1               last stage holds a beat
//  out_ready  in   1               downstream accepts beat
//  out_data   out  CHANNELS*WIDTH  last stage data
//  acc        out  CHANNELS*ACC_W  per-lane running sum of delivered beats
//  flush      in   1               request drain; level or pulse
//  flush_done out  1               one-cycle pulse when drain completes
//  busy       out  1               state != IDLE
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valids 0, stage data 0, acc 0, state IDLE, flush_done 0.
//    With rst=1, in_ready=0 and out_valid=0 regardless of other inputs.
//  - Stage k (0..DEPTH-1): valid_k, data_k.
//    adv_k = valid_k ? (k==DEPTH-1 ? out_ready : adv_{k+1} | ~valid_{k+1}) : 1.
//    Bubbles collapse: an empty stage always loads from its predecessor.
//  - in_ready = adv_0 & ~flush & (state != DRAIN) & ~rst; accept = in_valid & in_ready.
//  - Stage 0 loads masked data: lane c = in_chan_en[c] ? in_data lane c : 0.
//    Later stages copy unchanged. out_valid = valid_{DEPTH-1}; out_data = data_{DEPTH-1}.
//  - Latency: beat accepted in cycle t appears on out in cycle t+DEPTH when out_ready is held 1.
//    Throughput 1 beat/cycle. Full stall holds all DEPTH beats; no loss, no duplication.
//  - acc: on out_valid & out_ready, acc[c] += ext(out_data lane c) to ACC_W bits, modulo 2^ACC_W.
//    ext is signed or zero extension per SIGNED_MODE. Wrap is silent.
//  - FSM (enum in package): IDLE, RUN, DRAIN, DONE.
//    IDLE -> RUN   on accept & ~flush.
//    RUN  -> IDLE  when the pipe becomes empty and no accept this cycle.
//    IDLE/RUN -> DRAIN on flush=1; flush has priority over in_valid in the same cycle.
//    DRAIN -> DONE when all valids are 0 at the clock edge.
//    DONE  -> IDLE unconditionally; flush_done=1 only in DONE.
//    flush in IDLE with an empty pipe: DRAIN -> DONE in 2 cycles.
//    flush held through DONE does not retrigger until it is observed again in IDLE.
//  - Reset mid-drain: immediate return to IDLE; no flush_done pulse.
// STRUCTURE
//  - Package memo_pipe_pkg: typedef enum logic [1:0] memo_state_e {IDLE,RUN,DRAIN,DONE};
//    function lane_ext(WIDTH, ACC_W, signed flag).
//  - Sub-module memo_pipe_stage: one valid/data slot, parametrised by CHANNELS*WIDTH;
//    inputs clk, rst, load, d; outputs valid, q. Instantiated DEPTH times via generate.
//  - Top: adv chain (always_comb), FSM (always_ff + always_comb next-state),
//    accumulator generate loop over CHANNELS.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, acc=0, busy=0.
//  2. Streaming, DEPTH=3, out_ready=1: beats 0x01..0x05 on lane0 from t=0 ->
//     out at t=3..7 in order; acc lane0 = 15.
//  3. Stall: out_ready=0 after 3 accepts -> in_ready=0 in the 4th cycle.
//     Release -> 3 beats delivered in order, none lost.
//  4. Signed wrap: SIGNED_MODE=1, lane1 = 0x80 twice -> acc lane1 = 0xFF00.
//     SIGNED_MODE=0 -> 0x0100. in_chan_en=2'b01 -> lane1 contributes 0.
//  5. Flush with 2 beats in flight, out_ready=1 ->
//     in_ready=0 from the flush cycle; flush_done pulses 1 cycle after the last beat leaves; then IDLE.
//  6. Flush and in_valid asserted together in IDLE -> beat not accepted; flush_done 2 cycles later.
//     rst during DRAIN -> no flush_done.

Source files
------------

// File: rtl/memo_pipe_pkg.sv
// Shared types and helpers for the memo elastic pipeline.
// Holds the flush FSM state encoding and the lane extension function used by the accumulators.
package memo_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } memo_state_e;

    // Extends the low 'width' bits of v to 64 bits; callers truncate to their accumulator width.
    function automatic logic [63:0] lane_ext(input logic [63:0] v, input int width, input bit signed_flag);
        logic [63:0] hi_mask;
        hi_mask = ~64'd0 << width;
        if (signed_flag && v[6'(width - 1)]) begin
            return v | hi_mask;
        end
        return v & ~hi_mask;
    endfunction

endpackage

// File: rtl/memo_pipe_stage.sv
// One slot of the elastic pipeline: a valid bit plus a data word.
// The slot takes d_valid/d whenever load is high and otherwise holds its contents.
module memo_pipe_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= d_valid;
            q     <= d;
        end
    end

endmodule

// File: rtl/memo_elastic_pipe.sv
// Multi-lane elastic pipeline with bubble-collapsing stages, per-lane accumulators and a flush FSM.
// Handshake: a beat moves across an interface in a cycle where valid and ready are both 1 at posedge clk.
module memo_elastic_pipe
    import memo_pipe_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 3,
    parameter int SIGNED_MODE = 1,
    parameter int ACC_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_chan_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS*ACC_W-1:0] acc,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      busy
);

    localparam int DW = CHANNELS * WIDTH;

    memo_state_e state, state_nxt;

    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_valid;
    logic [DEPTH-1:0] nxt_valid;
    logic [DW-1:0]    stg_data [DEPTH];
    logic [DW-1:0]    src_data [DEPTH];
    logic [DW-1:0]    masked_data;
    logic             accept;
    logic             pipe_empty_next;

    always_comb begin
        masked_data = in_data;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!in_chan_en[c]) begin
                masked_data[c*WIDTH +: WIDTH] = '0;
            end
        end
    end

    // A stage advances when it is empty or its successor can take its beat this cycle.
    always_comb begin
        adv[DEPTH-1] = ~stg_valid[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = ~stg_valid[k] | adv[k+1] | ~stg_valid[k+1];
        end
    end

    assign in_ready = adv[0] & ~flush & (state != DRAIN) & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        src_valid[0] = accept;
        src_data[0]  = masked_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = stg_valid[k-1];
            src_data[k]  = stg_data[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            nxt_valid[k] = adv[k] ? src_valid[k] : stg_valid[k];
        end
        pipe_empty_next = ~|nxt_valid;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        memo_pipe_stage #(.W(DW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (adv[k]),
            .d_valid (src_valid[k]),
            .d       (src_data[k]),
            .valid   (stg_valid[k]),
            .q       (stg_data[k])
        );
    end

    assign out_valid = stg_valid[DEPTH-1];
    assign out_data  = stg_data[DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN completes on the edge that leaves every stage empty.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = DRAIN;
                end else if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = DRAIN;
                end else if (!accept && pipe_empty_next) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (pipe_empty_next) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign flush_done = (state == DONE);
    assign busy       = (state != IDLE);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_acc
        logic [ACC_W-1:0] acc_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_r <= '0;
            end else if (out_valid && out_ready) begin
                acc_r <= acc_r + ACC_W'(lane_ext(64'(out_data[c*WIDTH +: WIDTH]), WIDTH, SIGNED_MODE != 0));
            end
        end

        assign acc[c*ACC_W +: ACC_W] = acc_r;
    end

endmodule

// File: tb/tb_memo_elastic_pipe.sv
// Self-checking bench for memo_elastic_pipe: directed scenarios plus randomized traffic.
// A signed and an unsigned instance share stimulus; a queue/arithmetic model predicts data and sums.
module tb_memo_elastic_pipe;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 3;
    localparam int ACC_W    = 16;
    localparam int DW       = CHANNELS * WIDTH;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      out_ready = 1'b0;
    logic                      flush = 1'b0;
    logic [DW-1:0]             in_data = '0;
    logic [CHANNELS-1:0]       in_chan_en = '1;

    logic                      s_in_ready, s_out_valid, s_flush_done, s_busy;
    logic [DW-1:0]             s_out_data;
    logic [CHANNELS*ACC_W-1:0] s_acc;
    logic                      u_in_ready, u_out_valid, u_flush_done, u_busy;
    logic [DW-1:0]             u_out_data;
    logic [CHANNELS*ACC_W-1:0] u_acc;

    memo_elastic_pipe #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .SIGNED_MODE(1), .ACC_W(ACC_W)
    ) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .in_chan_en(in_chan_en), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .acc(s_acc), .flush(flush), .flush_done(s_flush_done), .busy(s_busy)
    );

    memo_elastic_pipe #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .SIGNED_MODE(0), .ACC_W(ACC_W)
    ) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
        .in_chan_en(in_chan_en), .out_valid(u_out_valid), .out_ready(out_ready), .out_data(u_out_data),
        .acc(u_acc), .flush(flush), .flush_done(u_flush_done), .busy(u_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int exp_rdy = -1;
    bit check_lat = 1'b0;
    int last_out_cycle = -1;
    int done_cycle = -1;
    int done_cnt = 0;

    logic [DW-1:0]    exp_q[$];
    int               lat_q[$];
    logic [ACC_W-1:0] m_acc_s [CHANNELS];
    logic [ACC_W-1:0] m_acc_u [CHANNELS];

    function automatic logic [DW-1:0] mask_lanes(input logic [DW-1:0] d, input logic [CHANNELS-1:0] en);
        logic [DW-1:0] r;
        r = d;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!en[c]) r[c*WIDTH +: WIDTH] = '0;
        end
        return r;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        lat_q.delete();
        for (int c = 0; c < CHANNELS; c++) begin
            m_acc_s[c] = '0;
            m_acc_u[c] = '0;
        end
    endtask

    // One cycle: inputs are already driven; sample mid-cycle, update the model, cross the edge.
    task automatic tick();
        logic [DW-1:0] exp_d;
        int t_in;
        #1;
        for (int c = 0; c < CHANNELS; c++) begin
            checks++;
            if (s_acc[c*ACC_W +: ACC_W] !== m_acc_s[c])
                $display("FAIL acc_signed lane%0d cyc=%0d got=%h exp=%h", c, cycle, s_acc[c*ACC_W +: ACC_W], m_acc_s[c]);
            if (s_acc[c*ACC_W +: ACC_W] !== m_acc_s[c]) errors++;
            checks++;
            if (u_acc[c*ACC_W +: ACC_W] !== m_acc_u[c]) begin
                errors++;
                $display("FAIL acc_unsigned lane%0d cyc=%0d got=%h exp=%h", c, cycle, u_acc[c*ACC_W +: ACC_W], m_acc_u[c]);
            end
        end
        if (exp_rdy >= 0) begin
            checks++;
            if (s_in_ready !== exp_rdy[0]) begin
                errors++;
                $display("FAIL in_ready cyc=%0d got=%b exp=%0d", cycle, s_in_ready, exp_rdy);
            end
        end
        if (flush || rst) begin
            checks++;
            if (s_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL in_ready_blocked cyc=%0d got=%b exp=0", cycle, s_in_ready);
            end
        end
        if (s_flush_done === 1'b1) begin
            done_cnt++;
            done_cycle = cycle;
        end
        if (in_valid && s_in_ready) begin
            exp_q.push_back(mask_lanes(in_data, in_chan_en));
            lat_q.push_back(cycle);
        end
        if (s_out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat cyc=%0d got=%h exp=none", cycle, s_out_data);
            end else begin
                exp_d = exp_q.pop_front();
                t_in  = lat_q.pop_front();
                if (s_out_data !== exp_d || u_out_data !== exp_d) begin
                    errors++;
                    $display("FAIL out_data cyc=%0d got=%h/%h exp=%h", cycle, s_out_data, u_out_data, exp_d);
                end
                if (check_lat) begin
                    checks++;
                    if (cycle - t_in != DEPTH) begin
                        errors++;
                        $display("FAIL latency cyc=%0d got=%0d exp=%0d", cycle, cycle - t_in, DEPTH);
                    end
                end
                for (int c = 0; c < CHANNELS; c++) begin
                    logic        [WIDTH-1:0] b;
                    logic signed [WIDTH-1:0] sb;
                    int vs, vu;
                    b  = exp_d[c*WIDTH +: WIDTH];
                    sb = b;
                    vs = sb;
                    vu = b;
                    m_acc_s[c] = m_acc_s[c] + vs[ACC_W-1:0];
                    m_acc_u[c] = m_acc_u[c] + vu[ACC_W-1:0];
                end
            end
            last_out_cycle = cycle;
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d_left exp=0_left", exp_q.size());
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        exp_rdy = -1;
        clear_model();
        repeat (2) begin
            #1;
            checks++;
            if (s_out_valid !== 1'b0 || s_busy !== 1'b0 || s_flush_done !== 1'b0 || u_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got=v%b b%b d%b exp=v0 b0 d0", s_out_valid, s_busy, s_flush_done);
            end
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (s_acc !== '0 || u_acc !== '0) begin
            errors++;
            $display("FAIL reset_acc got=%h/%h exp=0", s_acc, u_acc);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_chan_en = 2'b11;
        check_lat = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data = {8'h00, 8'(i)};
            exp_rdy = 1;
            tick();
        end
        in_valid = 1'b0;
        exp_rdy = -1;
        wait_drain(20);
        check_lat = 1'b0;
        #1;
        checks++;
        if (s_acc[ACC_W-1:0] !== 16'd15 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_sum got=%0d busy=%b exp=15 busy=0", s_acc[ACC_W-1:0], s_busy);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = DW'($urandom);
            exp_rdy = (i < DEPTH) ? 1 : 0;
            tick();
        end
        in_valid = 1'b0;
        exp_rdy = -1;
        out_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_signed_wrap();
        apply_reset();
        out_ready = 1'b1;
        in_chan_en = 2'b11;
        repeat (2) begin
            in_valid = 1'b1;
            in_data = {8'h80, 8'h00};
            tick();
        end
        in_valid = 1'b0;
        wait_drain(20);
        checks++;
        if (s_acc[ACC_W +: ACC_W] !== 16'hFF00 || u_acc[ACC_W +: ACC_W] !== 16'h0100) begin
            errors++;
            $display("FAIL signed_wrap got=%h/%h exp=ff00/0100", s_acc[ACC_W +: ACC_W], u_acc[ACC_W +: ACC_W]);
        end
        in_chan_en = 2'b01;
        in_valid = 1'b1;
        in_data = {8'h80, 8'h05};
        tick();
        in_valid = 1'b0;
        in_chan_en = 2'b11;
        wait_drain(20);
        checks++;
        if (s_acc[ACC_W +: ACC_W] !== 16'hFF00 || u_acc[ACC_W +: ACC_W] !== 16'h0100 || s_acc[ACC_W-1:0] !== 16'd5) begin
            errors++;
            $display("FAIL lane_disable got=%h/%h/%h exp=ff00/0100/0005", s_acc[ACC_W +: ACC_W], u_acc[ACC_W +: ACC_W], s_acc[ACC_W-1:0]);
        end
    endtask

    task automatic test_flush_inflight();
        out_ready = 1'b1;
        done_cnt = 0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data = DW'($urandom);
            tick();
        end
        flush = 1'b1;
        exp_rdy = 0;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        in_valid = 1'b0;
        exp_rdy = -1;
        repeat (6) tick();
        checks++;
        if (done_cnt != 1 || done_cycle != last_out_cycle + 1) begin
            errors++;
            $display("FAIL flush_done_inflight got=cnt%0d@%0d exp=cnt1@%0d", done_cnt, done_cycle, last_out_cycle + 1);
        end
        #1;
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_after got=%b exp=0", s_busy);
        end
    endtask

    task automatic test_flush_idle();
        int fcyc;
        done_cnt = 0;
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = DW'($urandom);
        exp_rdy = 0;
        fcyc = cycle;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_rdy = -1;
        repeat (5) tick();
        checks++;
        if (done_cnt != 1 || done_cycle != fcyc + 2) begin
            errors++;
            $display("FAIL flush_done_idle got=cnt%0d@%0d exp=cnt1@%0d", done_cnt, done_cycle, fcyc + 2);
        end
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        #1;
        if (s_busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_entered got=%b exp=1", s_busy);
        end
        rst = 1'b1;
        clear_model();
        done_cnt = 0;
        #1;
        checks++;
        if (s_busy !== 1'b0 || s_out_valid !== 1'b0 || s_flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drain got=b%b v%b d%b exp=b0 v0 d0", s_busy, s_out_valid, s_flush_done);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL no_done_after_reset got=%0d exp=0", done_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = DW'($urandom);
            in_chan_en = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            if (i < 150) begin
                flush = 1'b0;
                exp_rdy = (exp_q.size() < DEPTH || out_ready) ? 1 : 0;
            end else begin
                flush = ($urandom_range(0, 15) == 0);
                exp_rdy = -1;
            end
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        exp_rdy = -1;
        in_chan_en = 2'b11;
        wait_drain(30);
        repeat (3) tick();
    endtask

    initial begin
        clear_model();
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_signed_wrap();
        test_flush_inflight();
        test_flush_idle();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
